// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment readback path: legal glyphs (active-low a..g),
// FSM state encoding and the decoded-result record.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b1100000;
   localparam logic [6:0] SEG_C     = 7'b0110001;
   localparam logic [6:0] SEG_D     = 7'b1000010;
   localparam logic [6:0] SEG_E     = 7'b0110000;
   localparam logic [6:0] SEG_F     = 7'b0111000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam int STABLE_CYCLES_DEF = 4;

   typedef enum logic {ST_SETTLE, ST_PRESENT} state_e;

   typedef struct packed {
      logic       err;
      logic [3:0] value;
   } glyph_t;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational inverse of the hex display encoder; anything that is not one of
// the 16 hex glyphs reports err with value 0.
module seg7_glyph_decode
   import seg7_pkg::*;
(
   input  logic [6:0] seg,
   output glyph_t     glyph
);

   always_comb begin
      glyph.err   = 1'b0;
      glyph.value = 4'h0;
      case (seg)
         SEG_0:   glyph.value = 4'h0;
         SEG_1:   glyph.value = 4'h1;
         SEG_2:   glyph.value = 4'h2;
         SEG_3:   glyph.value = 4'h3;
         SEG_4:   glyph.value = 4'h4;
         SEG_5:   glyph.value = 4'h5;
         SEG_6:   glyph.value = 4'h6;
         SEG_7:   glyph.value = 4'h7;
         SEG_8:   glyph.value = 4'h8;
         SEG_9:   glyph.value = 4'h9;
         SEG_A:   glyph.value = 4'hA;
         SEG_B:   glyph.value = 4'hB;
         SEG_C:   glyph.value = 4'hC;
         SEG_D:   glyph.value = 4'hD;
         SEG_E:   glyph.value = 4'hE;
         SEG_F:   glyph.value = 4'hF;
         default: glyph.err   = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg7_readback.sv
// Samples the display pattern and sign, waits for it to settle, decodes it and
// offers each new settled result on a valid/ready handshake.
module seg7_readback
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       lcd,
   input  logic             lcd_o,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [3:0]       out_value,
   output logic             out_neg,
   output logic             out_err,
   output logic             overrun,
   output logic [CNT_W-1:0] deliver_cnt
);

   localparam logic [7:0]       SAMP_RST = {SEG_BLANK, 1'b0};
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(STABLE_CYCLES - 1);

   state_e           state_q, state_d;
   logic [7:0]       samp_q, samp_d;
   logic [7:0]       prev_q, prev_d;
   logic [7:0]       last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             first_q, first_d;
   logic             requal_q, requal_d;
   logic             out_valid_q, out_valid_d;
   logic [3:0]       out_value_q, out_value_d;
   logic             out_neg_q, out_neg_d;
   logic             out_err_q, out_err_d;
   logic             overrun_q, overrun_d;
   logic [CNT_W-1:0] deliver_cnt_q, deliver_cnt_d;

   logic             match;
   logic             settled;
   logic             fresh;
   logic             accept;
   logic [CNT_W-1:0] cnt_adv;
   glyph_t           glyph;

   seg7_glyph_decode u_decode (
      .seg   (samp_q[7:1]),
      .glyph (glyph)
   );

   always_comb begin
      samp_d = {lcd, lcd_o};
      prev_d = samp_q;

      // The compare right after an acceptance is disqualified so a pattern that
      // settled during PRESENT must re-qualify for the full window.
      match   = (samp_q == prev_q) && !requal_q;
      cnt_adv = !match ? '0 : (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
      settled = match && (cnt_adv == CNT_SAT);
      fresh   = settled && (first_q || (samp_q != last_q));
      accept  = out_valid_q && out_ready;

      state_d       = state_q;
      last_d        = last_q;
      cnt_d         = cnt_adv;
      first_d       = first_q;
      requal_d      = 1'b0;
      out_valid_d   = out_valid_q;
      out_value_d   = out_value_q;
      out_neg_d     = out_neg_q;
      out_err_d     = out_err_q;
      overrun_d     = overrun_q;
      deliver_cnt_d = deliver_cnt_q;

      case (state_q)
         ST_SETTLE: begin
            if (fresh) begin
               state_d     = ST_PRESENT;
               out_valid_d = 1'b1;
               out_value_d = glyph.value;
               out_err_d   = glyph.err;
               out_neg_d   = samp_q[0];
               last_d      = samp_q;
               first_d     = 1'b0;
            end
         end
         ST_PRESENT: begin
            if (accept) begin
               state_d       = ST_SETTLE;
               out_valid_d   = 1'b0;
               deliver_cnt_d = deliver_cnt_q + 1'b1;
               overrun_d     = 1'b0;
               cnt_d         = '0;
               requal_d      = 1'b1;
            end else if (fresh) begin
               overrun_d = 1'b1;
            end
         end
         default: state_d = ST_SETTLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_SETTLE;
         samp_q        <= SAMP_RST;
         prev_q        <= SAMP_RST;
         last_q        <= SAMP_RST;
         cnt_q         <= '0;
         first_q       <= 1'b1;
         requal_q      <= 1'b0;
         out_valid_q   <= 1'b0;
         out_value_q   <= 4'h0;
         out_neg_q     <= 1'b0;
         out_err_q     <= 1'b0;
         overrun_q     <= 1'b0;
         deliver_cnt_q <= '0;
      end else begin
         state_q       <= state_d;
         samp_q        <= samp_d;
         prev_q        <= prev_d;
         last_q        <= last_d;
         cnt_q         <= cnt_d;
         first_q       <= first_d;
         requal_q      <= requal_d;
         out_valid_q   <= out_valid_d;
         out_value_q   <= out_value_d;
         out_neg_q     <= out_neg_d;
         out_err_q     <= out_err_d;
         overrun_q     <= overrun_d;
         deliver_cnt_q <= deliver_cnt_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_value   = out_value_q;
   assign out_neg     = out_neg_q;
   assign out_err     = out_err_q;
   assign overrun     = overrun_q;
   assign deliver_cnt = deliver_cnt_q;

endmodule

// File: tb/tb_seg7_readback.sv
// Scoreboard bench for seg7_readback: directed display scenarios followed by random
// patterns, checked against an edge-indexed behavioural model of the readback rules.
module tb_seg7_readback;

   localparam int S     = 4;
   localparam int CNT_W = 8;
   localparam logic [7:0] RST_SAMP = {7'b1111111, 1'b0};
   localparam logic [6:0] GLYPH [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   typedef struct {
      logic [3:0] value;
      logic       neg;
      logic       err;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [6:0]       lcd;
   logic             lcd_o;
   logic             out_ready;
   logic             out_valid;
   logic [3:0]       out_value;
   logic             out_neg;
   logic             out_err;
   logic             overrun;
   logic [CNT_W-1:0] deliver_cnt;

   int n_cmp = 0;
   int n_err = 0;
   int n_xfer = 0;
   bit mon_en = 1'b0;

   // Model state: sampler history plus edge indices of the last disqualifying event.
   int             edge_n = 0;
   int             clear_edge = 0;
   int             accept_edge = -10;
   logic [7:0]     m_samp, m_prev, m_last;
   bit             m_first, m_valid, m_ovr;
   logic [CNT_W-1:0] m_dcnt;
   exp_t           exp_q[$];

   seg7_readback #(.STABLE_CYCLES(S), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .lcd         (lcd),
      .lcd_o       (lcd_o),
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .out_value   (out_value),
      .out_neg     (out_neg),
      .out_err     (out_err),
      .overrun     (overrun),
      .deliver_cnt (deliver_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] ref_decode(input logic [6:0] p);
      for (int v = 0; v < 16; v++)
         if (GLYPH[v] == p) return {1'b0, 4'(v)};
      return 5'b10000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      logic [7:0] cur;
      logic [4:0] dec;
      bit same, settled;
      edge_n++;
      cur = {lcd, lcd_o};
      if (!rst_n) begin
         m_samp = RST_SAMP; m_prev = RST_SAMP; m_last = RST_SAMP;
         m_first = 1'b1; m_valid = 1'b0; m_ovr = 1'b0; m_dcnt = '0;
         clear_edge = edge_n; accept_edge = -10;
         exp_q.delete();
      end else begin
         same = (m_samp == m_prev) && (edge_n != accept_edge + 1);
         if (!same) clear_edge = edge_n;
         settled = same && (edge_n - clear_edge >= S - 1);
         if (m_valid && out_ready) begin
            m_valid = 1'b0; m_dcnt++; m_ovr = 1'b0;
            clear_edge = edge_n; accept_edge = edge_n;
         end else if (settled && (m_first || m_samp != m_last)) begin
            if (m_valid) m_ovr = 1'b1;
            else begin
               dec = ref_decode(m_samp[7:1]);
               exp_q.push_back('{value: dec[3:0], neg: m_samp[0], err: dec[4]});
               m_last = m_samp; m_first = 1'b0; m_valid = 1'b1;
            end
         end
         m_prev = m_samp;
         m_samp = cur;
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         check("out_valid", 32'(out_valid), 32'(m_valid));
         check("overrun", 32'(overrun), 32'(m_ovr));
         check("deliver_cnt", 32'(deliver_cnt), 32'(m_dcnt));
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_result: got value=%0h with no result expected", out_value);
            end else begin
               check("out_value", 32'(out_value), 32'(exp_q[0].value));
               check("out_neg", 32'(out_neg), 32'(exp_q[0].neg));
               check("out_err", 32'(out_err), 32'(exp_q[0].err));
               if (out_ready && rst_n) begin
                  n_xfer++;
                  $display("xfer %0d: value=%0h neg=%0b err=%0b deliver_cnt=%0d",
                           n_xfer, out_value, out_neg, out_err, deliver_cnt);
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   task automatic drive(input logic [6:0] seg, input logic neg, input logic rdy, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         lcd = seg; lcd_o = neg; out_ready = rdy;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst_n = 1'b0; lcd = 7'b0000000; lcd_o = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      mon_en = 1'b1;
      @(posedge clk); #1;
      check("rst_out_value", 32'(out_value), 32'h0);
      check("rst_out_neg", 32'(out_neg), 32'h0);
      check("rst_out_err", 32'(out_err), 32'h0);
      check("rst_deliver_cnt", 32'(deliver_cnt), 32'h0);
      rst_n = 1'b1;
      drive(7'b0000000, 1'b0, 1'b1, 10);

      // add/sub results: 6/+, 1/+, 7/neg
      drive(7'b0100000, 1'b0, 1'b1, 10);
      drive(7'b1001111, 1'b0, 1'b1, 10);
      drive(7'b0001111, 1'b1, 1'b1, 10);

      // glitch shorter than the settle window, then back to an already-delivered 2
      drive(7'b0010010, 1'b0, 1'b1, 10);
      drive(7'b0000110, 1'b0, 1'b1, 2);
      drive(7'b0010010, 1'b0, 1'b1, 10);

      // backpressure and overrun
      drive(7'b0000100, 1'b0, 1'b0, 10);
      drive(7'b0001111, 1'b0, 1'b0, 10);
      drive(7'b0001111, 1'b0, 1'b1, 12);

      // illegal glyphs
      drive(7'b1111111, 1'b0, 1'b1, 10);
      drive(7'b0101010, 1'b0, 1'b1, 10);

      // reset while a result is pending
      drive(7'b0000001, 1'b0, 1'b0, 8);
      rst_n = 1'b0;
      drive(7'b0000001, 1'b0, 1'b0, 1);
      rst_n = 1'b1;
      drive(7'b0000001, 1'b0, 1'b0, 8);
      drive(7'b0000001, 1'b0, 1'b1, 5);

      // random patterns, sign, hold lengths and consumer stalls
      for (int seg_i = 0; seg_i < 80; seg_i++) begin
         logic [6:0] pat;
         logic       neg;
         int         hold;
         pat  = ($urandom_range(0, 3) != 0) ? GLYPH[$urandom_range(0, 15)] : 7'($urandom);
         neg  = 1'($urandom);
         hold = $urandom_range(1, 12);
         for (int c = 0; c < hold; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            drive(pat, neg, 1'($urandom_range(0, 3) != 0), 1);
         end
      end
      rst_n = 1'b1;
      drive(7'b0110001, 1'b1, 1'b1, 20);

      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL undelivered: got %0d results still pending, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
